// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality helper
// for the round-robin ALU arbiter.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational ALU shared by both requesters; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6
) (
    input  logic [NB_DATA-1:0] dato1,
    input  logic [NB_DATA-1:0] dato2,
    input  logic [NB_CODE-1:0] code,
    output logic [NB_DATA-1:0] result
);

    always_comb begin
        result = '0;
        case (code)
            NB_CODE'(OP_ADD): result = dato1 + dato2;
            NB_CODE'(OP_SUB): result = dato1 - dato2;
            NB_CODE'(OP_AND): result = dato1 & dato2;
            NB_CODE'(OP_OR):  result = dato1 | dato2;
            NB_CODE'(OP_XOR): result = dato1 ^ dato2;
            NB_CODE'(OP_NOR): result = ~(dato1 | dato2);
            // Shift counts at or beyond the width saturate to sign fill / zero.
            NB_CODE'(OP_SRA): result = $signed(dato1) >>> dato2;
            NB_CODE'(OP_SRL): result = dato1 >> dato2;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared ALU (IDLE/EXEC/DONE).
// Define ALU_ARB_BADOP_EN to add the err output flagging unlisted opcodes.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [NB_DATA-1:0] req0_dato1,
    input  logic [NB_DATA-1:0] req0_dato2,
    input  logic [NB_CODE-1:0] req0_code,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [NB_DATA-1:0] req1_dato1,
    input  logic [NB_DATA-1:0] req1_dato2,
    input  logic [NB_CODE-1:0] req1_code,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [NB_DATA-1:0] rsp_data,
    output logic               busy
`ifdef ALU_ARB_BADOP_EN
    ,
    output logic               err
`endif
);

    logic [1:0]         state;
    logic               ptr;
    logic               owner_p0;
    logic [NB_DATA-1:0] dato1_p0;
    logic [NB_DATA-1:0] dato2_p0;
    logic [NB_CODE-1:0] code_p0;
    logic [NB_DATA-1:0] alu_res;
    logic               accept;

    // Pointer only breaks ties; a lone valid requester always wins.
    assign req0_ready = (state == ST_IDLE) && req0_valid && (!req1_valid || !ptr);
    assign req1_ready = (state == ST_IDLE) && req1_valid && (!req0_valid || ptr);
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != ST_IDLE);

    // Stage p0: operand capture at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            dato1_p0 <= req1_ready ? req1_dato1 : req0_dato1;
            dato2_p0 <= req1_ready ? req1_dato2 : req0_dato2;
            code_p0  <= req1_ready ? req1_code  : req0_code;
        end
    end

    alu #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE)) u_alu (
        .dato1  (dato1_p0),
        .dato2  (dato2_p0),
        .code   (code_p0),
        .result (alu_res)
    );

    // Stage p1: result register and control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            owner_p0   <= 1'b0;
            rsp_data   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner_p0 <= req1_ready;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data   <= alu_res;
                    rsp0_valid <= !owner_p0;
                    rsp1_valid <= owner_p0;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    ptr        <= !owner_p0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_BADOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_EXEC) begin
            err <= !is_legal_op(6'(code_p0));
        end else begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a behavioural arbitration/ALU model.
// Build with ALU_ARB_BADOP_EN defined to also exercise the err output.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_dato1 = '0, req0_dato2 = '0, req1_dato1 = '0, req1_dato2 = '0;
    logic [5:0] req0_code = '0, req1_code = '0;
    logic       rsp0_valid, rsp1_valid, busy, err;
    logic [7:0] rsp_data;

    int n_checks = 0;
    int n_fail = 0;

    int         obs_lat, obs_width;
    logic       obs_r0, obs_r1, obs_e, obs_rdy_busy, obs_not_busy;
    logic [7:0] obs_d, obs_hold;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NB_DATA(8), .NB_CODE(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_dato1 (req0_dato1),
        .req0_dato2 (req0_dato2),
        .req0_code  (req0_code),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_dato1 (req1_dato1),
        .req1_dato2 (req1_dato2),
        .req1_code  (req1_code),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
`ifdef ALU_ARB_BADOP_EN
        ,
        .err        (err)
`endif
    );
`ifndef ALU_ARB_BADOP_EN
    assign err = 1'b0;
`endif

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] c);
        int ua, ub, sa;
        ua = int'(a);
        ub = int'(b);
        sa = a[7] ? ua - 256 : ua;
        case (c)
            OP_ADD: return 8'(ua + ub);
            OP_SUB: return 8'(ua - ub);
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_NOR: return ~(a | b);
            OP_SRL: return (ub >= 8) ? 8'h00 : 8'(ua / (1 << ub));
            OP_SRA: return (ub >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> ub);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic legal_ref(input logic [5:0] c);
        return c inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction

    task automatic set_req(input int k, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] c);
        if (k == 0) begin
            req0_valid = v; req0_dato1 = a; req0_dato2 = b; req0_code = c;
        end else begin
            req1_valid = v; req1_dato1 = a; req1_dato2 = b; req1_code = c;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with inputs set; returns just after the accept edge.
    task automatic do_accept(output int who, output int waits, output logic both_rdy);
        who = -1;
        waits = 0;
        both_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req0_ready && req1_ready) both_rdy = 1'b1;
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                waits = i;
                break;
            end
            @(negedge clk);
        end
        if (who >= 0) @(posedge clk);
    endtask

    // mode 0: hold inputs, 1: drop valids, 2: scramble all inputs during EXEC/DONE.
    task automatic wait_rsp(input int mode);
        obs_lat = 0; obs_width = 0; obs_r0 = 0; obs_r1 = 0; obs_d = '0; obs_e = 0;
        obs_rdy_busy = 0; obs_not_busy = 0; obs_hold = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                obs_width++;
                if (obs_lat == 0) begin
                    obs_lat = k; obs_r0 = rsp0_valid; obs_r1 = rsp1_valid; obs_d = rsp_data; obs_e = err;
                end
            end
            if (k < 3) begin
                if (req0_ready || req1_ready) obs_rdy_busy = 1;
                if (!busy) obs_not_busy = 1;
            end else begin
                obs_hold = rsp_data;
            end
            if (k == 1 && mode == 1) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end else if (k == 1 && mode == 2) begin
                set_req(0, 1'($urandom), 8'($urandom), 8'($urandom), 6'($urandom));
                set_req(1, 1'($urandom), 8'($urandom), 8'($urandom), 6'($urandom));
                #1;
                if (req0_ready || req1_ready) obs_rdy_busy = 1;
            end
        end
        if (mode == 2) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({busy, rsp0_valid, rsp1_valid, rsp_data, err} !== 12'h000)
            $display("FAIL reset_state: got busy=%b rsp=%b%b data=%h err=%b, want all 0",
                     busy, rsp0_valid, rsp1_valid, rsp_data, err);
        if ({busy, rsp0_valid, rsp1_valid, rsp_data, err} !== 12'h000) n_fail++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        int who, waits;
        logic both;
        @(negedge clk);
        set_req(0, 1'b1, 8'h7F, 8'h01, OP_ADD);
        do_accept(who, waits, both);
        wait_rsp(1);
        n_checks++;
        if (who !== 0 || {obs_r0, obs_r1, obs_d} !== {1'b1, 1'b0, 8'h80}) begin
            n_fail++;
            $display("FAIL add_wrap: grant=%0d rsp=%b%b data=%h, want grant=0 rsp=10 data=80", who, obs_r0, obs_r1, obs_d);
        end
        n_checks++;
        if (obs_lat !== 2 || obs_width !== 1 || obs_hold !== 8'h80) begin
            n_fail++;
            $display("FAIL add_timing: lat=%0d width=%0d hold=%h, want lat=2 width=1 hold=80", obs_lat, obs_width, obs_hold);
        end
    endtask

    task automatic test_priority();
        int who, waits;
        logic both;
        logic [7:0] exp_d[2] = '{8'hFE, 8'h30};
        apply_reset();
        set_req(0, 1'b1, 8'h05, 8'h07, OP_SUB);
        set_req(1, 1'b1, 8'hF0, 8'h3C, OP_AND);
        for (int n = 0; n < 2; n++) begin
            do_accept(who, waits, both);
            wait_rsp(0);
            n_checks++;
            if (who !== n || both !== 1'b0 || {obs_r0, obs_r1} !== {n == 0, n == 1} || obs_d !== exp_d[n]) begin
                n_fail++;
                $display("FAIL priority[%0d]: grant=%0d both=%b rsp=%b%b data=%h, want grant=%0d data=%h",
                         n, who, both, obs_r0, obs_r1, obs_d, n, exp_d[n]);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int who, waits;
        logic both;
        logic [7:0] a0, b0, a1, b1, exp;
        apply_reset();
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        set_req(0, 1'b1, a0, b0, OP_XOR);
        set_req(1, 1'b1, a1, b1, OP_SUB);
        for (int n = 0; n < 4; n++) begin
            do_accept(who, waits, both);
            wait_rsp(0);
            exp = (n % 2 == 0) ? alu_ref(a0, b0, OP_XOR) : alu_ref(a1, b1, OP_SUB);
            n_checks++;
            if (who !== n % 2 || obs_d !== exp || {obs_r0, obs_r1} !== {n % 2 == 0, n % 2 == 1}) begin
                n_fail++;
                $display("FAIL alternate[%0d]: grant=%0d data=%h rsp=%b%b, want grant=%0d data=%h",
                         n, who, obs_d, obs_r0, obs_r1, n % 2, exp);
            end
            n_checks++;
            if (obs_rdy_busy || obs_not_busy || (n > 0 && waits !== 0) || obs_lat !== 2) begin
                n_fail++;
                $display("FAIL throughput[%0d]: ready_when_busy=%b busy_low=%b waits=%0d lat=%0d, want 0 0 0 2",
                         n, obs_rdy_busy, obs_not_busy, waits, obs_lat);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_shifts();
        int who, waits;
        logic both;
        logic [5:0] tc[4] = '{OP_SRA, OP_SRL, OP_SRA, OP_NOR};
        logic [7:0] ta[4] = '{8'h80, 8'h80, 8'h80, 8'h0F};
        logic [7:0] tb[4] = '{8'h03, 8'h03, 8'h09, 8'hF0};
        logic [7:0] te[4] = '{8'hF0, 8'h10, 8'hFF, 8'h00};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            set_req(1, 1'b1, ta[n], tb[n], tc[n]);
            do_accept(who, waits, both);
            wait_rsp(1);
            n_checks++;
            if (who !== 1 || obs_d !== te[n] || {obs_r0, obs_r1} !== 2'b01) begin
                n_fail++;
                $display("FAIL shift[%0d]: grant=%0d data=%h rsp=%b%b, want grant=1 data=%h rsp=01",
                         n, who, obs_d, obs_r0, obs_r1, te[n]);
            end
        end
    endtask

    task automatic test_reset_exec();
        int who, waits, seen;
        logic both;
        apply_reset();
        set_req(0, 1'b1, 8'hAA, 8'h55, OP_XOR);
        do_accept(who, waits, both);
        wait_rsp(1);
        // Pointer now favours req1; a second req0 op is killed mid-flight.
        set_req(0, 1'b1, 8'h01, 8'h02, OP_ADD);
        do_accept(who, waits, both);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, rsp0_valid, rsp1_valid, rsp_data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_exec: busy=%b rsp=%b%b data=%h, want all 0", busy, rsp0_valid, rsp1_valid, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: activity cycles=%0d, want 0", seen);
        end
        set_req(0, 1'b1, 8'h10, 8'h20, OP_OR);
        set_req(1, 1'b1, 8'h10, 8'h20, OP_AND);
        do_accept(who, waits, both);
        wait_rsp(1);
        n_checks++;
        if (who !== 0 || obs_d !== 8'h30) begin
            n_fail++;
            $display("FAIL reset_ptr: grant=%0d data=%h, want grant=0 data=30", who, obs_d);
        end
    endtask

    task automatic test_badop();
        int who, waits;
        logic both;
        logic [5:0] tc[3] = '{6'b000000, OP_ADD, 6'b111111};
        logic [7:0] te[3] = '{8'h00, 8'h02, 8'h00};
        logic       tev[3] = '{1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            set_req(0, 1'b1, 8'h01, 8'h01, tc[n]);
            do_accept(who, waits, both);
            wait_rsp(1);
            n_checks++;
            if (obs_d !== te[n] || obs_r0 !== 1'b1) begin
                n_fail++;
                $display("FAIL badop_data[%0d]: data=%h rsp0=%b, want data=%h rsp0=1", n, obs_d, obs_r0, te[n]);
            end
`ifdef ALU_ARB_BADOP_EN
            n_checks++;
            if (obs_e !== tev[n]) begin
                n_fail++;
                $display("FAIL badop_err[%0d]: err=%b, want %b", n, obs_e, tev[n]);
            end
`else
            if (tev[n] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_random();
        int who, waits, g, ptr_m;
        logic both;
        logic [1:0] v;
        logic [7:0] a[2], b[2], exp;
        logic [5:0] c[2];
        logic [5:0] ops[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        apply_reset();
        ptr_m = 0;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                a[k] = 8'($urandom);
                b[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
                c[k] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                set_req(k, v[k], a[k], b[k], c[k]);
            end
            g = (v == 2'b11) ? ptr_m : (v[0] ? 0 : 1);
            exp = alu_ref(a[g], b[g], c[g]);
            do_accept(who, waits, both);
            wait_rsp(2);
            n_checks++;
            if (who !== g || both !== 1'b0 || obs_d !== exp || {obs_r0, obs_r1} !== {g == 0, g == 1} ||
                obs_lat !== 2 || obs_width !== 1 || obs_rdy_busy || obs_hold !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: grant=%0d data=%h rsp=%b%b lat=%0d w=%0d rdyb=%b, want grant=%0d data=%h lat=2 w=1",
                         n, who, obs_d, obs_r0, obs_r1, obs_lat, obs_width, obs_rdy_busy, g, exp);
            end
`ifdef ALU_ARB_BADOP_EN
            n_checks++;
            if (obs_e !== !legal_ref(c[g])) begin
                n_fail++;
                $display("FAIL random_err[%0d]: err=%b, want %b", n, obs_e, !legal_ref(c[g]));
            end
`endif
            ptr_m = 1 - g;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_priority();
        test_back_to_back();
        test_shifts();
        test_reset_exec();
        test_badop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
